// File: rtl/uart_tx_sched_if.sv
// Requester / transmitter bundle for the shared UART TX scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 18,
  parameter int IDW     = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_enable;
  logic                     ld_tx_data;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_busy;
  logic [IDW-1:0]           grant_id;
  logic [15:0]              frame_count;
  logic                     sched_busy;
  logic                     proto_err;

  modport master (
    input  req_valid, req_data, req_enable, tx_busy,
    output req_ready, ld_tx_data, tx_data, grant_id, frame_count, sched_busy, proto_err
  );

  modport slave (
    output req_valid, req_data, req_enable, tx_busy,
    input  req_ready, ld_tx_data, tx_data, grant_id, frame_count, sched_busy, proto_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
// state     | meaning
// IDLE      | no word in flight, waiting for an eligible request with tx_busy low
// LOAD      | one-cycle load strobe / accept pulse to the transmitter and winner
// WAIT_DONE | transmitter sending; grant again (or go idle) once tx_busy drops
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 18,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic            txclk,
  input  logic            reset_n,
  uart_tx_sched_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               first_wait_q;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     win;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               ld_q, ld_d;
  logic               proto_q, proto_d;
  logic               any_elig;
  logic               grant;

  assign elig = bus.req_valid & bus.req_enable;

  // Descending scan so the last hit is the first eligible index at or after rr_ptr.
  always_comb begin : arb
    int idx;
    idx      = 0;
    win      = '0;
    any_elig = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (elig[idx]) begin
        win      = IDW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  assign grant = any_elig && !bus.tx_busy &&
                 ((state_q == IDLE) || (state_q == WAIT_DONE));

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      first_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_wait_q <= (state_q == LOAD);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant) state_d = LOAD;
      LOAD:      state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = grant ? LOAD : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_d          = grant;
    req_ready_d   = '0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    frame_count_d = frame_count_q;
    // The transmitter must have raised tx_busy by the first WAIT_DONE cycle.
    proto_d       = proto_q | ((state_q == WAIT_DONE) && first_wait_q && !bus.tx_busy);
    if (grant) begin
      req_ready_d[win] = 1'b1;
      tx_data_d        = bus.req_data[int'(win)*WIDTH +: WIDTH];
      grant_id_d       = win;
      rr_ptr_d         = IDW'((int'(win) + 1) % NUM_REQ);
      frame_count_d    = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      ld_q          <= 1'b0;
      req_ready_q   <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      frame_count_q <= '0;
      proto_q       <= 1'b0;
    end else begin
      ld_q          <= ld_d;
      req_ready_q   <= req_ready_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      frame_count_q <= frame_count_d;
      proto_q       <= proto_d;
    end
  end

  assign bus.ld_tx_data  = ld_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.frame_count = frame_count_q;
  assign bus.sched_busy  = (state_q == LOAD) || (state_q == WAIT_DONE);
  assign bus.proto_err   = proto_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: random requesters, a 20-cycle-busy transmitter model
// and a grant scoreboard predicting winners from round-robin rules.
module tb_uart_tx_sched;
  localparam int N = 4;
  localparam int W = 18;

  logic txclk = 1'b0;
  logic reset_n;
  always #5 txclk = ~txclk;

  uart_tx_sched_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  uart_tx_sched #(.NUM_REQ(N), .WIDTH(W)) dut (.txclk(txclk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // requester controls (written by tests) and requester state (written by driver)
  int         budget [N];
  int         issued [N];
  logic       kill;
  logic       use_fixed [N];
  logic [W-1:0] fixed_word [N];
  logic       tx_dead;
  int         busy_cnt = 0;

  always @(posedge txclk) begin
    logic [N-1:0] r;
    r = bus.req_ready;
    #1;
    for (int i = 0; i < N; i++) begin
      if (kill || r[i]) bus.req_valid[i] = 1'b0;
      if (!kill && bus.req_valid[i] !== 1'b1 && issued[i] < budget[i]) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*W +: W]   = use_fixed[i] ? fixed_word[i] : W'($urandom);
        issued[i]                = issued[i] + 1;
      end
    end
  end

  // transmitter: latches on the edge that sees ld, busy for the next 20 cycles
  always @(posedge txclk) begin
    logic l;
    l = bus.ld_tx_data;
    #1;
    if (!tx_dead && l === 1'b1) begin
      busy_cnt    = 20;
      bus.tx_busy = 1'b1;
    end else begin
      if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      bus.tx_busy = (busy_cnt > 0);
    end
  end

  typedef struct {
    int           id;
    int           eid;
    logic [W-1:0] data;
    logic [W-1:0] edata;
    logic [N-1:0] ready;
    logic [15:0]  cnt;
    int           cyc;
    logic         busy;
  } grant_t;

  grant_t       g[$];
  int           m_ptr = 0;
  int           cyc = 0;
  int           stray = 0;
  logic [N-1:0] snap_elig = '0;
  logic [W-1:0] snap_data [N];

  always @(negedge txclk) begin
    grant_t e;
    int     win;
    cyc = cyc + 1;
    if (reset_n !== 1'b1) begin
      m_ptr = 0;
    end else if (bus.ld_tx_data === 1'b1) begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && snap_elig[(m_ptr + k) % N] === 1'b1) win = (m_ptr + k) % N;
      e.id    = int'(bus.grant_id);
      e.eid   = win;
      e.data  = bus.tx_data;
      e.edata = (win >= 0) ? snap_data[win] : '0;
      e.ready = bus.req_ready;
      e.cnt   = bus.frame_count;
      e.cyc   = cyc;
      e.busy  = bus.tx_busy;
      g.push_back(e);
      if (win >= 0) m_ptr = (win + 1) % N;
    end else if (bus.req_ready !== '0) begin
      stray = stray + 1;
    end
    snap_elig = bus.req_valid & bus.req_enable;
    for (int k = 0; k < N; k++) snap_data[k] = bus.req_data[k*W +: W];
  end

  task automatic step();
    @(negedge txclk);
    #1;
  endtask

  task automatic do_reset();
    kill = 1'b1;
    for (int i = 0; i < N; i++) budget[i] = issued[i];
    step();
    step();
    for (int c = 0; c < 40 && bus.tx_busy === 1'b1; c++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    kill = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.ld_tx_data !== 1'b0) begin errors++; $display("FAIL reset_ld got=%b exp=0", bus.ld_tx_data); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.tx_data !== 18'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count got=%h exp=0", bus.frame_count); end
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL reset_sched_busy got=%b exp=0", bus.sched_busy); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int b;
    do_reset();
    b = g.size();
    use_fixed[2]  = 1'b1;
    fixed_word[2] = 18'h2A5A5;
    budget[2]     = issued[2] + 1;
    for (int c = 0; c < 5 && bus.req_valid[2] !== 1'b1; c++) step();
    checks++; if (bus.ld_tx_data !== 1'b0) begin errors++; $display("FAIL single_no_comb_path ld got=%b exp=0", bus.ld_tx_data); end
    step();
    checks++; if (bus.ld_tx_data !== 1'b1) begin errors++; $display("FAIL single_latency ld got=%b exp=1", bus.ld_tx_data); end
    checks++; if (bus.tx_data !== 18'h2A5A5) begin errors++; $display("FAIL single_tx_data got=%h exp=2a5a5", bus.tx_data); end
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id got=%0d exp=2", bus.grant_id); end
    checks++; if (bus.frame_count !== 16'd1) begin errors++; $display("FAIL single_frame_count got=%0d exp=1", bus.frame_count); end
    step();
    checks++; if ({bus.ld_tx_data, bus.req_ready} !== 5'b0) begin errors++; $display("FAIL single_load_one_cycle got=%b exp=00000", {bus.ld_tx_data, bus.req_ready}); end
    checks++; if (bus.sched_busy !== 1'b1) begin errors++; $display("FAIL single_sched_busy got=%b exp=1", bus.sched_busy); end
    repeat (25) step();
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL single_back_idle got=%b exp=0", bus.sched_busy); end
    checks++; if (bus.tx_data !== 18'h2A5A5) begin errors++; $display("FAIL single_data_hold got=%h exp=2a5a5", bus.tx_data); end
    checks++; if (g.size() !== b + 1) begin errors++; $display("FAIL single_grant_count got=%0d exp=%0d", g.size() - b, 1); end
    use_fixed[2] = 1'b0;
  endtask

  task automatic test_round_robin();
    int b;
    do_reset();
    bus.req_enable = 4'b1111;
    b = g.size();
    for (int i = 0; i < N; i++) budget[i] = issued[i] + 8;
    for (int c = 0; c < 230 && g.size() < b + 8; c++) step();
    checks++; if (g.size() < b + 8) begin errors++; $display("FAIL rr_timeout grants got=%0d exp=8", g.size() - b); end
    for (int k = 0; k < 8 && b + k < g.size(); k++) begin
      checks++; if (g[b+k].id != k % N || g[b+k].ready !== 4'(1 << (k % N))) begin
        errors++; $display("FAIL rr_order k=%0d got id=%0d ready=%b exp id=%0d", k, g[b+k].id, g[b+k].ready, k % N); end
      checks++; if (g[b+k].id != g[b+k].eid || g[b+k].data !== g[b+k].edata) begin
        errors++; $display("FAIL rr_model k=%0d got id=%0d data=%h exp id=%0d data=%h", k, g[b+k].id, g[b+k].data, g[b+k].eid, g[b+k].edata); end
      checks++; if (g[b+k].cnt !== 16'(k + 1) || g[b+k].busy !== 1'b0) begin
        errors++; $display("FAIL rr_count_busy k=%0d got cnt=%0d busy=%b exp cnt=%0d busy=0", k, g[b+k].cnt, g[b+k].busy, k + 1); end
      if (k > 0) begin
        checks++; if (g[b+k].cyc - g[b+k-1].cyc != 22) begin
          errors++; $display("FAIL rr_period k=%0d got=%0d exp=22", k, g[b+k].cyc - g[b+k-1].cyc); end
      end
    end
  endtask

  task automatic test_mask();
    int b, s0;
    do_reset();
    bus.req_enable = 4'b1010;
    b  = g.size();
    s0 = stray;
    for (int i = 0; i < N; i++) budget[i] = issued[i] + 6;
    for (int c = 0; c < 180 && g.size() < b + 6; c++) step();
    checks++; if (g.size() < b + 6) begin errors++; $display("FAIL mask_timeout grants got=%0d exp=6", g.size() - b); end
    for (int k = 0; k < 6 && b + k < g.size(); k++) begin
      checks++; if (g[b+k].id != ((k % 2 == 0) ? 1 : 3) || g[b+k].data !== g[b+k].edata) begin
        errors++; $display("FAIL mask_order k=%0d got id=%0d exp id=%0d", k, g[b+k].id, (k % 2 == 0) ? 1 : 3); end
      checks++; if (g[b+k].ready[0] !== 1'b0 || g[b+k].ready[2] !== 1'b0) begin
        errors++; $display("FAIL mask_ready k=%0d got ready=%b exp bits0,2 low", k, g[b+k].ready); end
    end
    checks++; if (stray != s0) begin errors++; $display("FAIL mask_stray_ready got=%0d exp=0", stray - s0); end
  endtask

  task automatic test_wrap();
    int b;
    do_reset();
    bus.req_enable = 4'b1111;
    b = g.size();
    budget[0] = issued[0] + 1;
    for (int c = 0; c < 10 && g.size() < b + 1; c++) step();
    for (int c = 0; c < 40 && bus.sched_busy === 1'b1; c++) step();
    checks++; if (g.size() != b + 1 || bus.sched_busy !== 1'b0) begin
      errors++; $display("FAIL wrap_setup got grants=%0d busy=%b exp grants=1 busy=0", g.size() - b, bus.sched_busy); end
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    b = g.size();
    budget[0] = issued[0] + 1;
    budget[3] = issued[3] + 1;
    for (int c = 0; c < 60 && g.size() < b + 2; c++) step();
    checks++; if (g.size() < b + 2) begin errors++; $display("FAIL wrap_timeout grants got=%0d exp=2", g.size() - b); end
    else begin
      checks++; if (g[b].id != 3 || g[b].cnt !== 16'h0000) begin
        errors++; $display("FAIL wrap_first got id=%0d cnt=%h exp id=3 cnt=0000", g[b].id, g[b].cnt); end
      checks++; if (g[b+1].id != 0 || g[b+1].cnt !== 16'h0001) begin
        errors++; $display("FAIL wrap_second got id=%0d cnt=%h exp id=0 cnt=0001", g[b+1].id, g[b+1].cnt); end
      checks++; if (g[b].data !== g[b].edata || g[b+1].data !== g[b+1].edata) begin
        errors++; $display("FAIL wrap_data got=%h,%h exp=%h,%h", g[b].data, g[b+1].data, g[b].edata, g[b+1].edata); end
    end
  endtask

  task automatic test_proto_err();
    int b;
    do_reset();
    tx_dead = 1'b1;
    b = g.size();
    budget[1] = issued[1] + 3;
    for (int c = 0; c < 10 && g.size() < b + 1; c++) step();
    checks++; if (bus.ld_tx_data !== 1'b1 || bus.proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_load_cycle got ld=%b err=%b exp ld=1 err=0", bus.ld_tx_data, bus.proto_err); end
    step();
    checks++; if (bus.proto_err !== 1'b0 || bus.sched_busy !== 1'b1) begin
      errors++; $display("FAIL proto_first_wait got err=%b busy=%b exp err=0 busy=1", bus.proto_err, bus.sched_busy); end
    step();
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got=%b exp=1", bus.proto_err); end
    for (int c = 0; c < 20 && g.size() < b + 3; c++) step();
    repeat (5) step();
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%b exp=1", bus.proto_err); end
    checks++; if (g.size() != b + 3) begin errors++; $display("FAIL proto_continues grants got=%0d exp=3", g.size() - b); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (g[b+k].id != 1 || g[b+k].data !== g[b+k].edata || (k > 0 && g[b+k].cyc - g[b+k-1].cyc != 2)) begin
          errors++; $display("FAIL proto_grant k=%0d got id=%0d gap=%0d exp id=1 gap=2", k, g[b+k].id, (k > 0) ? g[b+k].cyc - g[b+k-1].cyc : 0); end
      end
    end
    tx_dead = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int b, early;
    do_reset();
    bus.req_enable = 4'b1111;
    b = g.size();
    early = 0;
    budget[0] = issued[0] + 1;
    for (int c = 0; c < 10 && g.size() < b + 1; c++) step();
    repeat (5) step();
    checks++; if (bus.sched_busy !== 1'b1) begin errors++; $display("FAIL mid_in_wait got=%b exp=1", bus.sched_busy); end
    reset_n = 1'b0;
    budget[2] = issued[2] + 1;
    #1;
    checks++; if ({bus.ld_tx_data, bus.req_ready, bus.sched_busy, bus.proto_err} !== 7'b0) begin
      errors++; $display("FAIL mid_async_ctrl got=%b exp=0000000", {bus.ld_tx_data, bus.req_ready, bus.sched_busy, bus.proto_err}); end
    checks++; if (bus.tx_data !== 18'h0 || bus.grant_id !== 2'd0 || bus.frame_count !== 16'h0) begin
      errors++; $display("FAIL mid_async_data got data=%h id=%0d cnt=%0d exp 0 0 0", bus.tx_data, bus.grant_id, bus.frame_count); end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 30 && bus.tx_busy === 1'b1; c++) begin
      if (bus.ld_tx_data !== 1'b0) early++;
      step();
    end
    checks++; if (early != 0 || g.size() != b + 1) begin
      errors++; $display("FAIL mid_wait_busy got early=%0d grants=%0d exp 0 1", early, g.size() - b); end
    for (int c = 0; c < 5 && g.size() < b + 2; c++) step();
    checks++; if (g.size() != b + 2) begin errors++; $display("FAIL mid_regrant_timeout got=%0d exp=2", g.size() - b); end
    else begin
      checks++; if (g[b+1].id != 2 || g[b+1].eid != 2 || g[b+1].cnt !== 16'd1 || g[b+1].busy !== 1'b0) begin
        errors++; $display("FAIL mid_regrant got id=%0d cnt=%0d busy=%b exp id=2 cnt=1 busy=0", g[b+1].id, g[b+1].cnt, g[b+1].busy); end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    kill           = 1'b1;
    tx_dead        = 1'b0;
    bus.req_enable = 4'b1111;
    for (int i = 0; i < N; i++) begin
      budget[i]     = 0;
      use_fixed[i]  = 1'b0;
      fixed_word[i] = '0;
    end
    repeat (3) step();
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_wrap();
    test_proto_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 18-bit UART transmitter between `NUM_REQ` on-chip requesters such as status, event and register-readback sources. It sits between the requesters and the UART TX block, on the same `txclk` baud clock. It arbitrates among pending words and drives the transmitter's `ld_tx_data`/`tx_data` load interface. It never loads while the transmitter reports `tx_busy`, and it flags protocol violations by the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 18: UART word width; must match the transmitter.
- `IDW`, default `$clog2(NUM_REQ)`: width of the requester index.

- `txclk`  in  1  baud-rate clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester word pending.
- `req_data`  in  NUM_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- `req_enable`  in  NUM_REQ  arbitration mask; 0 excludes that requester.
- `ld_tx_data`  out  1  load strobe to the transmitter.
- `tx_data`  out  WIDTH  word presented to the transmitter.
- `tx_busy`  in  1  transmitter busy.
- `grant_id`  out  IDW  index of the last granted requester.
- `frame_count`  out  16  number of words loaded.
- `sched_busy`  out  1  high in LOAD or WAIT_DONE.
- `proto_err`  out  1  sticky transmitter-protocol error.

## Operation
- FSM states: IDLE, LOAD, WAIT_DONE.
- **Grant condition.** A grant occurs when all of the following hold:
  - the state is IDLE, or the state is WAIT_DONE with `tx_busy`=0;
  - `tx_busy`=0;
  - at least one i has `req_valid[i] & req_enable[i]`.
- **Arbitration.** Round-robin. Search starts at `rr_ptr` and ascends with wrap-around modulo NUM_REQ. The first eligible i wins. After the grant, `rr_ptr` becomes (i+1) mod NUM_REQ.
- **On grant:**
  - register `tx_data` ← `req_data[i]`;
  - set `ld_tx_data`=1;
  - set `req_ready[i]`=1 and all other `req_ready` bits to 0;
  - set `grant_id` ← i;
  - increment `frame_count` (wraps 0xFFFF → 0);
  - move to LOAD.
- **LOAD.** Lasts exactly one cycle. `ld_tx_data` and `req_ready` return to 0 and the FSM moves to WAIT_DONE.
- **WAIT_DONE** is exited under either of these conditions:
  - `tx_busy`=0 with no eligible request: go to IDLE;
  - `tx_busy`=0 with an eligible request: grant directly.
- **Protocol check.** In the first WAIT_DONE cycle, `tx_busy` must be 1. If it is 0, set `proto_err`=1 (sticky until reset) and continue as the rules above dictate.
- **Idle cycles.** With no grant, `ld_tx_data`=0 and `req_ready`=0.
- **Data hold.** `tx_data` holds its last value between grants.
- **Requester obligations.** A requester holds `req_data` stable while `req_valid` is high. It drops `req_valid` or presents its next word on the edge after `req_ready`.
- **Mask.** Deasserting `req_enable[i]` affects only future arbitration, never a grant already issued.

## Timing
- **Reset values.** State IDLE; `rr_ptr`=0; `ld_tx_data`=0; `req_ready`=0; `tx_data`=0; `grant_id`=0; `frame_count`=0; `sched_busy`=0; `proto_err`=0.
- **Grant latency.** A request sampled at edge n in IDLE gives `ld_tx_data`=`req_ready`=1 in the cycle after edge n. These are registered outputs with no combinational path from `req_valid`.
- **Transmitter sequence.** The transmitter latches at edge n+1, `tx_busy` rises after edge n+1 and falls after edge n+21.
- **Back-to-back period.** With continuous requests, the next grant occurs at edge n+22, giving 22 cycles between consecutive `ld_tx_data` pulses.
- **Load isolation.** `ld_tx_data` is never high in any cycle in which `tx_busy`=1.
- **Reset mid-frame.** An asynchronous reset in any state forces all reset values immediately. After release, the first grant requires `tx_busy`=0.

## Test plan
1. **Single word.** Requester 2 presents 0x2A5A5 -> one `ld_tx_data` pulse with `tx_data`=0x2A5A5, `req_ready`=4'b0100, `grant_id`=2, `frame_count`=1.
2. **Round-robin fairness.** All 4 requesters valid continuously, `rr_ptr`=0 -> grant order 0,1,2,3,0,… with `ld_tx_data` pulses exactly 22 cycles apart; no `ld_tx_data` while `tx_busy`=1.
3. **Mask.** `req_enable`=4'b1010, all valid -> only requesters 1 and 3 are granted, alternating; `req_ready[0]` and `req_ready[2]` never assert.
4. **Wrap and sparse requests.** Requesters 3 and 0 valid, `rr_ptr`=1 -> 3 granted first, then 0; `frame_count` at 0xFFFF increments to 0x0000.
5. **Protocol error.** A transmitter model that holds `tx_busy`=0 after load -> `proto_err`=1 in the cycle after the first WAIT_DONE cycle and it stays 1; arbitration continues.
6. **Reset mid-frame.** `reset_n` pulsed low during WAIT_DONE -> all outputs return to reset values asynchronously; after release, no grant until `tx_busy`=0.
